// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
// Fetch stage and IF/ID pipeline register for a 5-stage RV32I pipeline.
// Owns the PC, drives the asynchronous-read instruction memory and presents
// {pc, pc+4, instr, valid} to decode. Fetch halts permanently on EBREAK
// until reset.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   stall           load-use stall: holds PC and IF/ID
//   flush           taken-branch flush: redirects PC, bubbles IF/ID
//   branch_target   redirect PC (low two bits dropped)
//   imem_addr       instruction memory address (= PC register)
//   imem_rdata      instruction word at imem_addr, same cycle
//   if_id_pc/pc4    PC of IF/ID instruction and that PC + 4
//   if_id_instr     IF/ID instruction word
//   if_id_valid     1 = real instruction, 0 = bubble
//   halted          1 once EBREAK has been latched into IF/ID
//
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count (advance edges)
// and flush_count (flush edges, any state), both cleared by rst.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        advance;

  // Next-state: flush > (HALT bubbling) > stall > advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    advance       = 1'b0;

    if (flush) begin
      pc_d          = branch_target & ~32'h3;
      if_id_pc_d    = '0;
      if_id_pc4_d   = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (state_q == S_HALT) begin
      // PC frozen; IF/ID keeps the EBREAK only while decode is stalled.
      if (!stall) begin
        if_id_pc_d    = '0;
        if_id_pc4_d   = '0;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
    end else if (!stall) begin
      advance       = 1'b1;
      pc_d          = pc_q + 32'd4;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_q + 32'd4;
      if_id_instr_d = imem_rdata;
      if_id_valid_d = 1'b1;
      if (imem_rdata == EBREAK) begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {31'd0, advance};
    flush_count_d = flush_count_q + {31'd0, flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`else
  logic advance_unused;
  assign advance_unused = advance;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT 0: RESET_PC = 0 ----------------
  logic        rst, stall, flush;
  logic [31:0] tgt, imem_addr, imem_rdata;
  logic [31:0] o_pc, o_pc4, o_instr;
  logic        o_valid, o_halted;
  logic        ebk_en;
  logic [7:0]  ebk_lo;

  // Instruction memory contents: addr | A000_0000, with an optional EBREAK
  // at any address whose low byte equals ebk_lo.
  function automatic logic [31:0] imem_fn(input logic [31:0] a, input logic en,
                                          input logic [7:0] lo);
    if (en && a[7:0] == lo) return EBRK;
    return a | 32'hA000_0000;
  endfunction

  assign imem_rdata = imem_fn(imem_addr, ebk_en, ebk_lo);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt0, flcnt0, fcnt1, flcnt1;
`endif

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(tgt), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(o_pc), .if_id_pc4(o_pc4), .if_id_instr(o_instr),
    .if_id_valid(o_valid), .halted(o_halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt0), .flush_count(flcnt0)
`endif
  );

  // ---------------- DUT 1: RESET_PC near the top of memory ----------------
  logic        rst1;
  logic        stall1 = 1'b0;
  logic        flush1 = 1'b0;
  logic [31:0] tgt1 = 32'h0;
  logic [31:0] addr1, rdata1, pc1, pc41, instr1;
  logic        valid1, halted1;
  assign rdata1 = addr1 | 32'hA000_0000;

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut1 (
    .clk(clk), .rst(rst1), .stall(stall1), .flush(flush1),
    .branch_target(tgt1), .imem_addr(addr1), .imem_rdata(rdata1),
    .if_id_pc(pc1), .if_id_pc4(pc41), .if_id_instr(instr1),
    .if_id_valid(valid1), .halted(halted1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt1), .flush_count(flcnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, flush, ebk;
    logic [31:0] tgt;
    logic [31:0] pc, ipc, ipc4, instr;
    logic        valid, halted;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic e,
                              input logic [31:0] t, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic [31:0] ipc4,
                              input logic [31:0] ins, input logic v, input logic h);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.ebk = e; x.tgt = t;
    x.pc = pc; x.ipc = ipc; x.ipc4 = ipc4; x.instr = ins; x.valid = v; x.halted = h;
    return x;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc, ipc, ipc4, instr, fcnt, flcnt;
    logic        valid, halted;
  } model_t;

  function automatic model_t bubble(input model_t m);
    model_t n = m;
    n.ipc = 0; n.ipc4 = 0; n.instr = NOP; n.valid = 0;
    return n;
  endfunction

  function automatic model_t step(input model_t m, input logic r, input logic s,
                                  input logic f, input logic [31:0] t,
                                  input logic [31:0] word);
    model_t n = m;
    if (r) begin
      n = bubble(n);
      n.pc = 0; n.halted = 0; n.fcnt = 0; n.flcnt = 0;
    end else if (f) begin
      n = bubble(n);
      n.pc = (t / 4) * 4;
      n.flcnt = m.flcnt + 1;
    end else if (m.halted) begin
      if (!s) n = bubble(n);
    end else if (!s) begin
      n.ipc = m.pc; n.ipc4 = m.pc + 4; n.instr = word; n.valid = 1;
      n.pc = m.pc + 4;
      n.fcnt = m.fcnt + 1;
      if (word == EBRK) n.halted = 1;
    end
    return n;
  endfunction

  vec_t   vecs[30];
  model_t m;

  initial begin
    rst = 1; stall = 0; flush = 0; tgt = 0; ebk_en = 0; ebk_lo = 8'h0C; rst1 = 1;

    //             rst stl fls ebk tgt          pc           ipc          ipc4         instr        v  h
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   NOP,           0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   32'h4,   32'hA000_0000, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,   32'h8,   32'h4,   32'h8,   32'hA000_0004, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,   32'hC,   32'h8,   32'hC,   32'hA000_0008, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   32'h10,  32'hA000_000C, 1, 0);
    vecs[5]  = mk(0, 1, 0, 0, 32'h0,   32'h10,  32'hC,   32'h10,  32'hA000_000C, 1, 0);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0,   32'h10,  32'hC,   32'h10,  32'hA000_000C, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,   32'h14,  32'h10,  32'h14,  32'hA000_0010, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,   32'h18,  32'h14,  32'h18,  32'hA000_0014, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,   32'h1C,  32'h18,  32'h1C,  32'hA000_0018, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,   32'h20,  32'h1C,  32'h20,  32'hA000_001C, 1, 0);
    vecs[11] = mk(0, 1, 1, 0, 32'h103, 32'h100, 32'h0,   32'h0,   NOP,           0, 0);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,   32'h104, 32'h100, 32'h104, 32'hA000_0100, 1, 0);
    vecs[13] = mk(1, 0, 0, 1, 32'h0,   32'h0,   32'h0,   32'h0,   NOP,           0, 0);
    vecs[14] = mk(0, 0, 0, 1, 32'h0,   32'h4,   32'h0,   32'h4,   32'hA000_0000, 1, 0);
    vecs[15] = mk(0, 0, 0, 1, 32'h0,   32'h8,   32'h4,   32'h8,   32'hA000_0004, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 32'h0,   32'hC,   32'h8,   32'hC,   32'hA000_0008, 1, 0);
    vecs[17] = mk(0, 0, 0, 1, 32'h0,   32'h10,  32'hC,   32'h10,  EBRK,          1, 1);
    vecs[18] = mk(0, 1, 0, 1, 32'h0,   32'h10,  32'hC,   32'h10,  EBRK,          1, 1);
    vecs[19] = mk(0, 0, 0, 1, 32'h0,   32'h10,  32'h0,   32'h0,   NOP,           0, 1);
    vecs[20] = mk(0, 0, 0, 1, 32'h0,   32'h10,  32'h0,   32'h0,   NOP,           0, 1);
    vecs[21] = mk(0, 0, 1, 1, 32'h200, 32'h200, 32'h0,   32'h0,   NOP,           0, 1);
    vecs[22] = mk(0, 0, 0, 1, 32'h0,   32'h200, 32'h0,   32'h0,   NOP,           0, 1);
    vecs[23] = mk(1, 0, 0, 1, 32'h0,   32'h0,   32'h0,   32'h0,   NOP,           0, 0);
    vecs[24] = mk(0, 0, 0, 1, 32'h0,   32'h4,   32'h0,   32'h4,   32'hA000_0000, 1, 0);
    vecs[25] = mk(0, 0, 0, 1, 32'h0,   32'h8,   32'h4,   32'h8,   32'hA000_0004, 1, 0);
    vecs[26] = mk(0, 0, 0, 1, 32'h0,   32'hC,   32'h8,   32'hC,   32'hA000_0008, 1, 0);
    vecs[27] = mk(0, 0, 1, 1, 32'h40,  32'h40,  32'h0,   32'h0,   NOP,           0, 0);
    vecs[28] = mk(0, 0, 0, 1, 32'h0,   32'h44,  32'h40,  32'h44,  32'hA000_0040, 1, 0);
    vecs[29] = mk(1, 1, 1, 1, 32'h80,  32'h0,   32'h0,   32'h0,   NOP,           0, 0);

    #1;
    for (int i = 0; i < 30; i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
      tgt = vecs[i].tgt; ebk_en = vecs[i].ebk;
      @(posedge clk); #1;
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].pc);
      check($sformatf("v%0d if_id_pc", i), o_pc, vecs[i].ipc);
      check($sformatf("v%0d if_id_pc4", i), o_pc4, vecs[i].ipc4);
      check($sformatf("v%0d if_id_instr", i), o_instr, vecs[i].instr);
      check($sformatf("v%0d if_id_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d halted", i), {31'd0, o_halted}, {31'd0, vecs[i].halted});
    end

    // ---------------- PC wrap on the second instance ----------------
    @(posedge clk); #1;
    rst1 = 0;
    check("wrap reset pc", addr1, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap adv1 if_id_pc", pc1, 32'hFFFF_FFF8);
    check("wrap adv1 pc", addr1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap adv2 if_id_pc", pc1, 32'hFFFF_FFFC);
    check("wrap adv2 if_id_pc4", pc41, 32'h0);
    check("wrap adv2 pc", addr1, 32'h0);
    @(posedge clk); #1;
    check("wrap adv3 if_id_pc", pc1, 32'h0);
    check("wrap adv3 if_id_instr", instr1, 32'hA000_0000);
    check("wrap halted", {31'd0, halted1}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("wrap fetch_count", fcnt1, 32'd3);
    check("wrap flush_count", flcnt1, 32'd0);
`endif

    // ---------------- randomized run against the reference model ----------------
    m = '{default: 0};
    rst = 1; stall = 0; flush = 0; ebk_en = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] word;
      if (c > 0) begin
        rst   = ($urandom_range(0, 99) < 3);
        stall = ($urandom_range(0, 99) < 25);
        flush = ($urandom_range(0, 99) < 12);
        tgt   = $urandom & 32'h0000_03FF;
        if ($urandom_range(0, 49) == 0) begin
          ebk_en = $urandom_range(0, 1) == 1;
          ebk_lo = 8'($urandom_range(0, 63) * 4);
        end
      end
      word = imem_fn(m.pc, ebk_en, ebk_lo);
      @(posedge clk);
      m = step(m, rst, stall, flush, tgt, word);
      #1;
      check("rnd imem_addr", imem_addr, m.pc);
      check("rnd if_id_pc", o_pc, m.ipc);
      check("rnd if_id_pc4", o_pc4, m.ipc4);
      check("rnd if_id_instr", o_instr, m.instr);
      check("rnd if_id_valid", {31'd0, o_valid}, {31'd0, m.valid});
      check("rnd halted", {31'd0, o_halted}, {31'd0, m.halted});
`ifdef FETCH_PERF_CNT_EN
      check("rnd fetch_count", fcnt0, m.fcnt);
      check("rnd flush_count", flcnt0, m.flcnt);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage RV32I hazard pipeline.
- Owns the PC and drives the instruction-memory address.
- Consumes the flush and branch-target redirect produced by the ID-stage branch resolution logic, and the stall from the load-use hazard detector.
- Presents {pc, pc+4, instr, valid} to the decode stage; halts fetch permanently on EBREAK until reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into IF/ID on flush or reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  load-use stall from hazard detector; holds PC and IF/ID.
- flush  input  1  branch-taken flush from ID-stage branch logic.
- branch_target  input  32  redirect PC, sampled when flush=1.
- imem_addr  output  32  instruction memory address; equals current PC (combinational from PC register).
- imem_rdata  input  32  instruction word at imem_addr, valid same cycle (asynchronous-read memory).
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_pc4  output  32  if_id_pc + 4.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- halted  output  1  1 once EBREAK has been latched into IF/ID.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of any other input: pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, FSM=RUN.
- FSM states: RUN, HALT.
  - RUN -> HALT when a word equal to 32'h0010_0073 (EBREAK) is loaded into IF/ID by a normal advance.
  - HALT is exited only by rst.
- Priority each edge in RUN: flush > stall > advance.
  - flush=1:
    - pc <= {branch_target[31:2],2'b00}.
    - IF/ID <= {pc=0, pc4=0, instr=NOP_INSTR, valid=0}.
    - Overrides stall; an EBREAK currently on imem_rdata is discarded and no halt occurs.
  - stall=1, flush=0: pc and all IF/ID fields hold their values.
  - Advance (both 0):
    - if_id_pc <= pc; if_id_pc4 <= pc+4; if_id_instr <= imem_rdata; if_id_valid <= 1.
    - pc <= pc+4.
- In HALT:
  - pc holds.
  - IF/ID holds the EBREAK with valid=1 if stall=1; otherwise IF/ID is loaded with a bubble (NOP_INSTR, valid=0).
  - flush in HALT: pc <= target and IF/ID bubbled; state stays HALT and pc does not advance afterwards.
- halted = (state==HALT), registered.
- Arithmetic: pc+4 is modulo 2^32; pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Latency:
  - Redirect: target instruction reaches IF/ID one cycle after the flush edge, i.e. exactly one bubble per taken branch.
  - Stall: adds one held cycle per stalled cycle.
- imem_addr changes only on clock edges; never glitches on inputs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count[31:0] (increments on each advance edge) and flush_count[31:0] (increments on each flush edge in any state).
  - Both counters are cleared by rst and wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then 4 free cycles with RESET_PC=0, imem returning addr|32'hA000_0000 -> if_id_pc sequence 0,4,8 with valid=1 from the 2nd edge; if_id_instr=32'hA000_0008 when if_id_pc=8.
- stall=1 for 2 cycles while pc=0x10 -> pc stays 0x10, IF/ID unchanged for 2 cycles, then resumes with if_id_pc=0x10.
- flush=1 with stall=1, branch_target=0x103 at pc=0x20 -> next cycle pc=0x100, if_id_valid=0, if_id_instr=0x13; following cycle if_id_pc=0x100, valid=1.
- EBREAK at 0x0C -> halted=1 after it enters IF/ID, pc frozen at 0x10, subsequent IF/ID bubbles; rst clears halted and pc=RESET_PC.
- EBREAK on imem_rdata in the same cycle as flush=1 -> no halt, pc=branch_target.
- RESET_PC=32'hFFFF_FFF8, run 3 cycles -> pc wraps to 0, if_id_pc4 of the 0xFFFF_FFFC instruction equals 0; with FETCH_PERF_CNT_EN, fetch_count=3, flush_count=0.
